// File: rtl/gemm_insn_issuer.sv
// gemm_insn_issuer: packs GEMM/FINISH instruction fields into the 128-bit VTA
// instruction word, screens out malformed instructions, and queues legal words
// in a small FIFO presented to the gemm core over a valid/ready handshake.
module gemm_insn_issuer #(
    parameter int unsigned INS_WIDTH  = 128,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 3,
    parameter int unsigned DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enc_valid,
    output logic                  enc_ready,
    input  logic [2:0]            opcode,
    input  logic [3:0]            dep_flags,
    input  logic                  reset_reg,
    input  logic [12:0]           uop_bgn,
    input  logic [13:0]           uop_end,
    input  logic [13:0]           iter_out,
    input  logic [13:0]           iter_in,
    input  logic [10:0]           dst_factor_out,
    input  logic [10:0]           dst_factor_in,
    input  logic [10:0]           src_factor_out,
    input  logic [10:0]           src_factor_in,
    input  logic [9:0]            wgt_factor_out,
    input  logic [9:0]            wgt_factor_in,
    output logic [INS_WIDTH-1:0]  insn,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic [DROP_WIDTH-1:0] drop_cnt,
    output logic                  drop_pulse
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]      PTR_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [DROP_WIDTH-1:0] DROP_ONE = 1;

    typedef enum logic [2:0] {
        OP_GEMM   = 3'd2,
        OP_FINISH = 3'd3
    } opcode_e;

    logic [INS_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [INS_WIDTH-1:0] pack_word;
    logic                 legal;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Handshake and status flags come only from registered state.
    assign enc_ready  = (count != CNT_FULL);
    assign insn_valid = (count != '0);
    assign occupancy  = count;
    // Head word; forced to zero while empty so reset leaves insn at zero
    // without having to clear the storage array.
    assign insn       = insn_valid ? mem[rd_ptr] : '0;

    assign pack_word = INS_WIDTH'({1'b0,
                                   wgt_factor_in, wgt_factor_out,
                                   src_factor_in, src_factor_out,
                                   dst_factor_in, dst_factor_out,
                                   iter_in, iter_out,
                                   uop_end, uop_bgn,
                                   reset_reg, dep_flags, opcode});

    // Screen the presented field set: FINISH always passes, GEMM needs a
    // non-empty uop range and non-zero loop counts, anything else is dropped.
    always_comb begin
        legal = 1'b0;
        if (opcode == OP_FINISH) begin
            legal = 1'b1;
        end else if (opcode == OP_GEMM) begin
            legal = ({1'b0, uop_bgn} < uop_end) && (iter_out != '0) && (iter_in != '0);
        end
    end

    assign accept = enc_valid && enc_ready;
    assign push   = accept && legal;
    assign drop   = accept && !legal;
    assign pop    = insn_valid && insn_ready;

    // FIFO storage write; contents need no reset because occupancy gates insn.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pack_word;
        end
    end

    // Pointers, explicit occupancy, and the drop counter/pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            drop_pulse <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_gemm_insn_issuer.sv
// Directed self-checking bench for gemm_insn_issuer.
module tb_gemm_insn_issuer;

    logic         clk;
    logic         rst;
    logic         enc_valid;
    logic         enc_ready;
    logic [2:0]   opcode;
    logic [3:0]   dep_flags;
    logic         reset_reg;
    logic [12:0]  uop_bgn;
    logic [13:0]  uop_end;
    logic [13:0]  iter_out;
    logic [13:0]  iter_in;
    logic [10:0]  dst_factor_out;
    logic [10:0]  dst_factor_in;
    logic [10:0]  src_factor_out;
    logic [10:0]  src_factor_in;
    logic [9:0]   wgt_factor_out;
    logic [9:0]   wgt_factor_in;
    logic [127:0] insn;
    logic         insn_valid;
    logic         insn_ready;
    logic [2:0]   occupancy;
    logic [7:0]   drop_cnt;
    logic         drop_pulse;

    int checks;
    int errors;
    logic [127:0] exp_q[$];

    gemm_insn_issuer #(
        .INS_WIDTH (128),
        .DEPTH     (4),
        .CNT_WIDTH (3),
        .DROP_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enc_valid     (enc_valid),
        .enc_ready     (enc_ready),
        .opcode        (opcode),
        .dep_flags     (dep_flags),
        .reset_reg     (reset_reg),
        .uop_bgn       (uop_bgn),
        .uop_end       (uop_end),
        .iter_out      (iter_out),
        .iter_in       (iter_in),
        .dst_factor_out(dst_factor_out),
        .dst_factor_in (dst_factor_in),
        .src_factor_out(src_factor_out),
        .src_factor_in (src_factor_in),
        .wgt_factor_out(wgt_factor_out),
        .wgt_factor_in (wgt_factor_in),
        .insn          (insn),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .occupancy     (occupancy),
        .drop_cnt      (drop_cnt),
        .drop_pulse    (drop_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Legal GEMM field set, every field derived from a small tag.
    task automatic set_legal(input logic [10:0] tag);
        opcode         = 3'd2;
        dep_flags      = tag[3:0];
        reset_reg      = tag[0];
        uop_bgn        = {2'b00, tag};
        uop_end        = {3'b000, tag} + 14'd8;
        iter_out       = 14'd2;
        iter_in        = 14'd3;
        dst_factor_out = tag;
        dst_factor_in  = tag + 11'd1;
        src_factor_out = tag + 11'd2;
        src_factor_in  = tag + 11'd3;
        wgt_factor_out = tag[9:0] + 10'd4;
        wgt_factor_in  = tag[9:0] + 10'd5;
    endtask

    // Expected word for set_legal(tag), built field by field from the layout.
    function automatic logic [127:0] exp_legal(input logic [10:0] tag);
        logic [127:0] e;
        e          = '0;
        e[2:0]     = 3'd2;
        e[6:3]     = tag[3:0];
        e[7]       = tag[0];
        e[20:8]    = {2'b00, tag};
        e[34:21]   = {3'b000, tag} + 14'd8;
        e[48:35]   = 14'd2;
        e[62:49]   = 14'd3;
        e[73:63]   = tag;
        e[84:74]   = tag + 11'd1;
        e[95:85]   = tag + 11'd2;
        e[106:96]  = tag + 11'd3;
        e[116:107] = tag[9:0] + 10'd4;
        e[126:117] = tag[9:0] + 10'd5;
        e[127]     = 1'b0;
        return e;
    endfunction

    task automatic test_reset();
        rst        = 1'b0;
        enc_valid  = 1'b0;
        insn_ready = 1'b0;
        set_legal(11'd0);
        #3;
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_insn_valid got %0b want 0", insn_valid); end
        checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL reset_enc_ready got %0b want 1", enc_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse got %0b want 0", drop_pulse); end
        checks++; if (insn !== 128'd0) begin errors++; $display("FAIL reset_insn got %h want 0", insn); end
        #8;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        insn_ready     = 1'b1;
        opcode         = 3'd2;
        dep_flags      = 4'd0;
        reset_reg      = 1'b0;
        uop_bgn        = 13'd1;
        uop_end        = 14'h10;
        iter_out       = 14'd4;
        iter_in        = 14'd4;
        dst_factor_out = 11'd1;
        dst_factor_in  = 11'd1;
        src_factor_out = 11'd4;
        src_factor_in  = 11'd4;
        wgt_factor_out = 10'd4;
        wgt_factor_in  = 10'd4;
        enc_valid      = 1'b1;
        cyc();
        enc_valid = 1'b0;
        checks++; if (insn_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", insn_valid); end
        checks++; if (insn[2:0] !== 3'd2) begin errors++; $display("FAIL single_opcode got %0d want 2", insn[2:0]); end
        checks++; if (insn[20:8] !== 13'd1) begin errors++; $display("FAIL single_uop_bgn got %0d want 1", insn[20:8]); end
        checks++; if (insn[34:21] !== 14'h10) begin errors++; $display("FAIL single_uop_end got %0d want 16", insn[34:21]); end
        checks++; if (insn[48:35] !== 14'd4) begin errors++; $display("FAIL single_iter_out got %0d want 4", insn[48:35]); end
        checks++; if (insn[62:49] !== 14'd4) begin errors++; $display("FAIL single_iter_in got %0d want 4", insn[62:49]); end
        checks++; if (insn[73:63] !== 11'd1) begin errors++; $display("FAIL single_dst_out got %0d want 1", insn[73:63]); end
        checks++; if (insn[84:74] !== 11'd1) begin errors++; $display("FAIL single_dst_in got %0d want 1", insn[84:74]); end
        checks++; if (insn[95:85] !== 11'd4) begin errors++; $display("FAIL single_src_out got %0d want 4", insn[95:85]); end
        checks++; if (insn[106:96] !== 11'd4) begin errors++; $display("FAIL single_src_in got %0d want 4", insn[106:96]); end
        checks++; if (insn[116:107] !== 10'd4) begin errors++; $display("FAIL single_wgt_out got %0d want 4", insn[116:107]); end
        checks++; if (insn[126:117] !== 10'd4) begin errors++; $display("FAIL single_wgt_in got %0d want 4", insn[126:117]); end
        checks++; if (insn[127] !== 1'b0) begin errors++; $display("FAIL single_msb got %0b want 0", insn[127]); end
        checks++; if (insn[7:3] !== 5'd0) begin errors++; $display("FAIL single_flags got %0d want 0", insn[7:3]); end
        cyc();
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b want 0", insn_valid); end
    endtask

    task automatic test_fill();
        insn_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_legal(11'(i + 1));
            enc_valid = 1'b1;
            if (i < 4) begin
                checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %0b want 1", i, enc_ready); end
            end
            cyc();
        end
        enc_valid = 1'b1;
        checks++; if (enc_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b want 0", enc_ready); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occupancy got %0d want 4", occupancy); end
        checks++; if (insn !== exp_legal(11'd1)) begin errors++; $display("FAIL fill_head_stable got %h want %h", insn, exp_legal(11'd1)); end
        enc_valid = 1'b0;
        insn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (insn !== exp_legal(11'(i + 1))) begin errors++; $display("FAIL fill_order_%0d got %h want %h", i, insn, exp_legal(11'(i + 1))); end
            cyc();
        end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL fill_drained got %0b want 0", insn_valid); end
    endtask

    task automatic test_drop();
        insn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_legal(11'(i + 7));
            if (i == 0) begin
                uop_bgn = 13'h10;
                uop_end = 14'h10;
            end else if (i == 1) begin
                iter_in = 14'd0;
            end else begin
                opcode = 3'd5;
            end
            enc_valid = 1'b1;
            checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_%0d got %0b want 1", i, enc_ready); end
            cyc();
            enc_valid = 1'b0;
            checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse_%0d got %0b want 1", i, drop_pulse); end
            checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drop_occupancy_%0d got %0d want 0", i, occupancy); end
            cyc();
            checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_end_%0d got %0b want 0", i, drop_pulse); end
        end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_cnt got %0d want 3", drop_cnt); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %0b want 0", insn_valid); end
    endtask

    task automatic test_full_pop();
        insn_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_legal(11'(i + 10));
            enc_valid = 1'b1;
            cyc();
            exp_q.push_back(exp_legal(11'(i + 10)));
        end
        // Full: pop and offered push in the same cycle -> only the pop happens.
        set_legal(11'd14);
        enc_valid  = 1'b1;
        insn_ready = 1'b1;
        cyc();
        void'(exp_q.pop_front());
        insn_ready = 1'b0;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fullpop_occupancy got %0d want 3", occupancy); end
        checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready got %0b want 1", enc_ready); end
        checks++; if (insn !== exp_q[0]) begin errors++; $display("FAIL fullpop_head got %h want %h", insn, exp_q[0]); end
        cyc();
        exp_q.push_back(exp_legal(11'd14));
        enc_valid = 1'b0;
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fullpop_next_push got %0d want 4", occupancy); end
        insn_ready = 1'b1;
        cyc();
        void'(exp_q.pop_front());
        cyc();
        void'(exp_q.pop_front());
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL half_occupancy got %0d want 2", occupancy); end
        for (int i = 0; i < 20; i++) begin
            set_legal(11'(i + 20));
            enc_valid = 1'b1;
            checks++; if (insn !== exp_q[0]) begin errors++; $display("FAIL concurrent_head_%0d got %h want %h", i, insn, exp_q[0]); end
            cyc();
            void'(exp_q.pop_front());
            exp_q.push_back(exp_legal(11'(i + 20)));
            checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL concurrent_occupancy_%0d got %0d want 2", i, occupancy); end
        end
        enc_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (insn !== exp_q[0]) begin errors++; $display("FAIL tail_head_%0d got %h want %h", i, insn, exp_q[0]); end
            cyc();
            void'(exp_q.pop_front());
        end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL concurrent_drained got %0b want 0", insn_valid); end
    endtask

    task automatic test_reset_mid();
        insn_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_legal(11'(i + 50));
            enc_valid = 1'b1;
            cyc();
        end
        enc_valid = 1'b0;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL midrst_pre_occupancy got %0d want 3", occupancy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", insn_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL midrst_occupancy got %0d want 0", occupancy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_drop_cnt got %0d want 0", drop_cnt); end
        checks++; if (insn !== 128'd0) begin errors++; $display("FAIL midrst_insn got %h want 0", insn); end
        checks++; if (enc_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b want 1", enc_ready); end
        #3;
        rst = 1'b1;
        cyc();
        insn_ready = 1'b1;
        set_legal(11'd99);
        enc_valid = 1'b1;
        cyc();
        enc_valid = 1'b0;
        checks++; if (insn !== exp_legal(11'd99)) begin errors++; $display("FAIL midrst_first_word got %h want %h", insn, exp_legal(11'd99)); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL midrst_first_occ got %0d want 1", occupancy); end
        cyc();
    endtask

    task automatic test_saturate();
        insn_ready = 1'b1;
        set_legal(11'd3);
        opcode    = 3'd0;
        enc_valid = 1'b1;
        for (int i = 0; i < 254; i++) cyc();
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", drop_cnt); end
        cyc();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", drop_cnt); end
        for (int i = 0; i < 45; i++) cyc();
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", drop_cnt); end
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse got %0b want 1", drop_pulse); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL sat_occupancy got %0d want 0", occupancy); end
        enc_valid = 1'b0;
        cyc();
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL sat_pulse_end got %0b want 0", drop_pulse); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_fill();
        test_drop();
        test_full_pop();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemm_insn_issuer.md
Name: gemm_insn_issuer

Overview:
Packs individually presented GEMM/FINISH instruction fields into the 128-bit VTA instruction word consumed by the gemm core. Buffers packed words in a small FIFO and presents them to the core over a valid/ready handshake. Sits between the compute-side instruction fetch/decode logic and the gemm core's insn input. Malformed instructions are screened and dropped before they reach the core.

Parameters:
INS_WIDTH, 128, packed instruction width; fixed layout below.
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_WIDTH, 3, occupancy counter width; equals log2(DEPTH)+1.
DROP_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-low reset.
enc_valid  input  1  field set valid.
enc_ready  output  1  issuer can accept a field set.
opcode  input  3  2 = GEMM, 3 = FINISH.
dep_flags  input  4  {push_next, push_prev, pop_next, pop_prev}.
reset_reg  input  1  reset-accumulator flag.
uop_bgn  input  13  first micro-op index.
uop_end  input  14  end micro-op index, exclusive.
iter_out  input  14  outer loop count.
iter_in  input  14  inner loop count.
dst_factor_out, dst_factor_in  input  11 each  accumulator index strides.
src_factor_out, src_factor_in  input  11 each  input index strides.
wgt_factor_out, wgt_factor_in  input  10 each  weight index strides.
insn  output  128  packed instruction at FIFO head.
insn_valid  output  1  head entry valid.
insn_ready  input  1  gemm core consumes head.
occupancy  output  CNT_WIDTH  entries held.
drop_cnt  output  DROP_WIDTH  dropped instruction count, saturating.
drop_pulse  output  1  one-cycle pulse per dropped instruction.

Behaviour:
- Packing layout, LSB first:
  - [2:0] opcode, [6:3] dep_flags, [7] reset_reg
  - [20:8] uop_bgn, [34:21] uop_end
  - [48:35] iter_out, [62:49] iter_in
  - [73:63] dst_out, [84:74] dst_in
  - [95:85] src_out, [106:96] src_in
  - [116:107] wgt_out, [126:117] wgt_in
  - [127] forced 0.
- Accept condition: enc_valid && enc_ready. enc_ready = (occupancy != DEPTH), combinational from registered state only.
- Legal instruction:
  - opcode==3 (FINISH) is always legal.
  - opcode==2 (GEMM) is legal only when {1'b0,uop_bgn} < uop_end, iter_out != 0 and iter_in != 0.
  - Every other opcode is illegal.
- Legal accepted instruction: packed word written to the FIFO tail at the clock edge.
- Illegal accepted instruction: handshake completes, nothing is written, drop_pulse=1 for the next cycle only, drop_cnt increments and holds at all-ones.
- insn and insn_valid are driven from the registered head. insn_valid = (occupancy != 0). Pop on insn_valid && insn_ready.
- insn is held stable while insn_valid && !insn_ready.
- Latency: an accepted legal word is visible on insn one cycle after the accept edge when the FIFO was empty. There is no combinational bypass.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - When full, push is blocked by enc_ready=0, so a pop while full frees a slot for the next cycle only.
- When empty, insn_ready is ignored.
- Pointers wrap modulo DEPTH. occupancy is tracked explicitly, never derived from pointer difference.
- Reset (asynchronous, any time, including mid-transfer):
  - pointers, occupancy, drop_cnt and drop_pulse = 0
  - insn_valid = 0, enc_ready = 1
  - insn = 0; FIFO storage need not be cleared.
- In-flight entries are discarded at reset; the core sees insn_valid fall immediately.

Test Plan:
1. Reset, push GEMM with opcode 2, uop_bgn 1, uop_end 0x10, iter 4/4, dst 1/1, src 4/4, wgt 4/4; hold insn_ready=1 -> one cycle later insn_valid=1 with insn[2:0]=2, [20:8]=1, [34:21]=0x10, [48:35]=4, [62:49]=4, [73:63]=1, [106:96]=4, [126:117]=4, [127]=0.
2. insn_ready=0, push 5 legal words -> enc_ready=0 after 4th, occupancy=4, 5th held off. Then insn_ready=1 -> words emerge in order, head stable while stalled.
3. Push GEMM with uop_bgn 0x10, uop_end 0x10; then GEMM with iter_in 0; then opcode 5 -> all handshakes complete, occupancy stays 0, drop_cnt=3, three single-cycle drop_pulses.
4. Full FIFO, same-cycle pop and enc_valid -> pop only; push is accepted on the following cycle. Half-full concurrent push/pop for 20 cycles -> occupancy constant, pointer wrap keeps order.
5. Assert rst low mid-stream with occupancy 3 -> insn_valid=0, occupancy=0, drop_cnt=0 immediately. After release, first new push appears intact.
6. 300 illegal pushes -> drop_cnt saturates at 255.
